// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial adder/subtractor.
// Each operation consumes WIDTH/DIGIT clocks, LSB digit first, through a chain of
// DIGIT full-adder cells. Results are held in output registers between completions.
// The completing edge can also accept a new start, so a continuously held start
// gives one result every WIDTH/DIGIT cycles with no idle gap.
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] opa_reg, opa_next;
  logic [WIDTH-1:0] opb_reg, opb_next;
  logic [WIDTH-1:0] res_reg, res_next;
  logic             carry_reg, carry_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic             done_reg, done_next;

  // Digit datapath: carry chain through DIGIT full-adder cells.
  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] res_shift;
  logic             load;

  assign chain[0] = carry_reg;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
      assign dsum[gi]      = opa_reg[gi] ^ opb_reg[gi] ^ chain[gi];
      assign chain[gi + 1] = (opa_reg[gi] & opb_reg[gi]) |
                             (chain[gi] & (opa_reg[gi] ^ opb_reg[gi]));
    end
  endgenerate

  // New digit enters at the top of the result register; after N digits the
  // first digit has travelled down to bit 0.
  assign res_shift = (res_reg >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

  // Next-state and datapath update; load also fires on the completing edge.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    opa_next   = opa_reg;
    opb_next   = opb_reg;
    res_next   = res_reg;
    carry_next = carry_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    done_next  = 1'b0;
    load       = 1'b0;

    case (state_reg)
      IDLE: begin
        load = start;
      end
      RUN: begin
        opa_next   = opa_reg >> DIGIT;
        opb_next   = opb_reg >> DIGIT;
        res_next   = res_shift;
        carry_next = chain[DIGIT];
        cnt_next   = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          sum_next   = res_shift;
          cout_next  = chain[DIGIT];
          ovf_next   = chain[DIGIT-1] ^ chain[DIGIT];
          done_next  = 1'b1;
          state_next = IDLE;
          load       = start;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Subtract is a + ~b + 1: invert b once at capture and seed the carry with 1.
    if (load) begin
      opa_next   = a;
      opb_next   = mode ? ~b : b;
      carry_next = mode ? 1'b1 : cin;
      res_next   = '0;
      cnt_next   = '0;
      state_next = RUN;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      opa_reg   <= opa_next;
      opb_reg   <= opb_next;
      res_reg   <= res_next;
      carry_reg <= carry_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
      done_reg  <= done_next;
    end
  end

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule
